// File: rtl/uart_pkg.sv
// Shared UART constants for the TX and RX blocks: FSM state indices,
// one-hot state encodings, data width and line levels for start/stop bits.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  // One-hot bit positions of the receiver FSM.
  localparam int ST_IDLE      = 0;
  localparam int ST_START     = 1;
  localparam int ST_DATA      = 2;
  localparam int ST_STOP      = 3;
  localparam int ST_WAIT_IDLE = 4;
  localparam int NUM_STATES   = 5;

  localparam logic [NUM_STATES-1:0] S_IDLE      = 5'b00001;
  localparam logic [NUM_STATES-1:0] S_START     = 5'b00010;
  localparam logic [NUM_STATES-1:0] S_DATA      = 5'b00100;
  localparam logic [NUM_STATES-1:0] S_STOP      = 5'b01000;
  localparam logic [NUM_STATES-1:0] S_WAIT_IDLE = 5'b10000;

  localparam logic START_BIT_LVL = 1'b0;
  localparam logic STOP_BIT_LVL  = 1'b1;

endpackage

// File: rtl/uart_rx_filter.sv
// RXD front end: 2-flop synchronizer, optionally followed by a 2-of-3
// majority vote over the last three synchronized samples.
// Build option: UART_RX_MAJORITY_EN enables the majority filter.
module uart_rx_filter (
  input  logic clk,
  input  logic sync_reset,
  input  logic rxd,
  output logic line
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  // Synchronizer next-state: plain shift of the async line.
  always_comb begin
    sync1_d = rxd;
    sync2_d = sync1_q;
  end

  // Synchronizer flops; reset to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic hist1_q, hist1_d;
  logic hist2_q, hist2_d;

  // History of the two previous synchronized samples.
  always_comb begin
    hist1_d = sync2_q;
    hist2_d = hist1_q;
  end

  // History flops; all ones so the filter starts at idle level.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      hist1_q <= 1'b1;
      hist2_q <= 1'b1;
    end else begin
      hist1_q <= hist1_d;
      hist2_q <= hist2_d;
    end
  end

  // 2-of-3 vote: a single-cycle glitch never wins.
  always_comb begin
    line = (sync2_q & hist1_q) | (sync2_q & hist2_q) | (hist1_q & hist2_q);
  end
`else
  // No filter: the receiver sees the second synchronizer flop directly.
  always_comb begin
    line = sync2_q;
  end
`endif

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Start edge is qualified at half a bit, each data bit
// and the stop bit are sampled at bit centres by a reloading down-counter.
// Build option: UART_RX_MAJORITY_EN selects the majority-vote RXD filter.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_PERIOD_BITS = 16
) (
  input  logic                        clk,
  input  logic                        sync_reset,
  input  logic                        enable_RX,
  input  logic [BAUD_PERIOD_BITS-1:0] baud_rate_period_m1,
  input  logic                        RXD,
  output logic [7:0]                  SBUF_out,
  output logic                        rx_valid,
  output logic                        frame_error,
  output logic                        rx_active
);

  localparam logic [BAUD_PERIOD_BITS-1:0] CNT_ONE = 1;

  logic                        line;
  logic                        expiry;
  logic [NUM_STATES-1:0]       state_q, state_d;
  logic [BAUD_PERIOD_BITS-1:0] cnt_q, cnt_d;
  logic [2:0]                  idx_q, idx_d;
  logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
  logic [UART_DATA_BITS-1:0]   sbuf_q, sbuf_d;
  logic                        rx_valid_q, rx_valid_d;
  logic                        frame_error_q, frame_error_d;

  uart_rx_filter u_filter (
    .clk        (clk),
    .sync_reset (sync_reset),
    .rxd        (RXD),
    .line       (line)
  );

  // FSM, bit timer and shifter next-state logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    shift_d       = shift_q;
    sbuf_d        = sbuf_q;
    rx_valid_d    = 1'b0;
    frame_error_d = 1'b0;
    expiry        = (cnt_q == '0);

    case (1'b1)
      state_q[ST_IDLE]: begin
        // enable_RX only gates the start of a frame, never aborts one.
        if (enable_RX && line == START_BIT_LVL) begin
          state_d = S_START;
          cnt_d   = baud_rate_period_m1 >> 1;
        end
      end
      state_q[ST_START]: begin
        if (expiry) begin
          if (line == START_BIT_LVL) begin
            state_d = S_DATA;
            cnt_d   = baud_rate_period_m1;
            idx_d   = 3'd0;
          end else begin
            state_d = S_IDLE;  // too short to be a start bit
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      state_q[ST_DATA]: begin
        if (expiry) begin
          shift_d = {line, shift_q[UART_DATA_BITS-1:1]};  // LSB first
          idx_d   = idx_q + 3'd1;
          cnt_d   = baud_rate_period_m1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      state_q[ST_STOP]: begin
        if (expiry) begin
          if (line == STOP_BIT_LVL) begin
            sbuf_d     = shift_q;
            rx_valid_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            frame_error_d = 1'b1;
            state_d       = S_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      state_q[ST_WAIT_IDLE]: begin
        // Hold off until the line recovers so a break is not a new start.
        if (line == STOP_BIT_LVL) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      sbuf_q        <= '0;
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      sbuf_q        <= sbuf_d;
      rx_valid_q    <= rx_valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  // Output mapping.
  always_comb begin
    SBUF_out    = sbuf_q;
    rx_valid    = rx_valid_q;
    frame_error = frame_error_q;
    rx_active   = ~state_q[ST_IDLE];
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: reset, clean frames, framing error with break,
// start glitch, back-to-back frames, enable gating, mid-frame reset, fast baud.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        sync_reset = 1'b1;
  logic        enable_RX = 1'b1;
  logic [15:0] baud_rate_period_m1 = 16'd15;
  logic        RXD = 1'b1;
  logic [7:0]  SBUF_out;
  logic        rx_valid;
  logic        frame_error;
  logic        rx_active;

  int vec_cnt = 0;
  int err_cnt = 0;
  int bit_clks = 16;

  logic [7:0] got_q[$];
  int fe_cnt = 0;
  int both_hi = 0;

  uart_rx #(.BAUD_PERIOD_BITS(16)) dut (
    .clk                 (clk),
    .sync_reset          (sync_reset),
    .enable_RX           (enable_RX),
    .baud_rate_period_m1 (baud_rate_period_m1),
    .RXD                 (RXD),
    .SBUF_out            (SBUF_out),
    .rx_valid            (rx_valid),
    .frame_error         (frame_error),
    .rx_active           (rx_active)
  );

  always #5 clk = ~clk;

  // Record output pulses away from the active edge.
  always @(negedge clk) begin
    if (rx_valid) got_q.push_back(SBUF_out);
    if (frame_error) fe_cnt++;
    if (rx_valid && frame_error) both_hi++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    RXD = 1'b1;
    repeat (n) tick();
  endtask

  task automatic clear_mon();
    got_q.delete();
    fe_cnt = 0;
    both_hi = 0;
  endtask

  // Drive one 8N1 frame. glitch_bit inverts one mid-bit cycle of that data
  // bit; abort_bit returns halfway into that data bit; en_off_bit drops
  // enable_RX at the start of that data bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_lvl,
                            input int glitch_bit, input int abort_bit,
                            input int en_off_bit);
    logic [9:0] fr;
    fr = {stop_lvl, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (i >= 1 && i - 1 == en_off_bit) enable_RX = 1'b0;
      for (int c = 0; c < bit_clks; c++) begin
        if (i >= 1 && i - 1 == abort_bit && c == bit_clks / 2) return;
        if (i >= 1 && i - 1 == glitch_bit && c == bit_clks / 2) RXD = ~fr[i];
        else RXD = fr[i];
        tick();
      end
    end
  endtask

  task automatic test_reset();
    sync_reset = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    vec_cnt++; if (SBUF_out !== 8'h00) begin err_cnt++; $display("FAIL reset_sbuf got=%h exp=00", SBUF_out); end
    vec_cnt++; if (rx_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    vec_cnt++; if (frame_error !== 1'b0) begin err_cnt++; $display("FAIL reset_frame_error got=%b exp=0", frame_error); end
    vec_cnt++; if (rx_active !== 1'b0) begin err_cnt++; $display("FAIL reset_rx_active got=%b exp=0", rx_active); end
    sync_reset = 1'b0;
    idle(4);
  endtask

  task automatic test_single();
    clear_mon();
    send_frame(8'hA5, 1'b1, -1, -1, -1);
    idle(2 * bit_clks);
    @(negedge clk);
    vec_cnt++; if (got_q.size() !== 1) begin err_cnt++; $display("FAIL single_count got=%0d exp=1", got_q.size()); end
    else begin
      vec_cnt++; if (got_q[0] !== 8'hA5) begin err_cnt++; $display("FAIL single_value got=%h exp=a5", got_q[0]); end
    end
    vec_cnt++; if (fe_cnt !== 0) begin err_cnt++; $display("FAIL single_fe got=%0d exp=0", fe_cnt); end
    vec_cnt++; if (SBUF_out !== 8'hA5) begin err_cnt++; $display("FAIL single_sbuf got=%h exp=a5", SBUF_out); end
    vec_cnt++; if (rx_active !== 1'b0) begin err_cnt++; $display("FAIL single_active got=%b exp=0", rx_active); end
  endtask

  task automatic test_frame_error();
    clear_mon();
    send_frame(8'h3C, 1'b0, -1, -1, -1);
    RXD = 1'b0;
    repeat (40) tick();
    @(negedge clk);
    vec_cnt++; if (fe_cnt !== 1) begin err_cnt++; $display("FAIL ferr_count got=%0d exp=1", fe_cnt); end
    vec_cnt++; if (got_q.size() !== 0) begin err_cnt++; $display("FAIL ferr_valid got=%0d exp=0", got_q.size()); end
    vec_cnt++; if (SBUF_out !== 8'hA5) begin err_cnt++; $display("FAIL ferr_sbuf_kept got=%h exp=a5", SBUF_out); end
    vec_cnt++; if (rx_active !== 1'b1) begin err_cnt++; $display("FAIL ferr_wait_idle got=%b exp=1", rx_active); end
    idle(3 * bit_clks);
    @(negedge clk);
    vec_cnt++; if (rx_active !== 1'b0) begin err_cnt++; $display("FAIL ferr_back_idle got=%b exp=0", rx_active); end
    vec_cnt++; if (fe_cnt !== 1) begin err_cnt++; $display("FAIL ferr_no_second got=%0d exp=1", fe_cnt); end
    vec_cnt++; if (got_q.size() !== 0) begin err_cnt++; $display("FAIL ferr_no_frame got=%0d exp=0", got_q.size()); end
  endtask

  task automatic test_glitch();
    clear_mon();
    RXD = 1'b0;
    repeat (4) tick();
    idle(3 * bit_clks);
    @(negedge clk);
    vec_cnt++; if (got_q.size() !== 0) begin err_cnt++; $display("FAIL glitch_valid got=%0d exp=0", got_q.size()); end
    vec_cnt++; if (fe_cnt !== 0) begin err_cnt++; $display("FAIL glitch_fe got=%0d exp=0", fe_cnt); end
    vec_cnt++; if (rx_active !== 1'b0) begin err_cnt++; $display("FAIL glitch_idle got=%b exp=0", rx_active); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_v [3];
    exp_v[0] = 8'h00; exp_v[1] = 8'hFF; exp_v[2] = 8'h55;
    clear_mon();
    for (int k = 0; k < 3; k++) send_frame(exp_v[k], 1'b1, -1, -1, -1);
    idle(2 * bit_clks);
    @(negedge clk);
    vec_cnt++; if (got_q.size() !== 3) begin err_cnt++; $display("FAIL b2b_count got=%0d exp=3", got_q.size()); end
    else begin
      for (int k = 0; k < 3; k++) begin
        vec_cnt++; if (got_q[k] !== exp_v[k]) begin err_cnt++; $display("FAIL b2b_value%0d got=%h exp=%h", k, got_q[k], exp_v[k]); end
      end
    end
    vec_cnt++; if (both_hi !== 0 || fe_cnt !== 0) begin err_cnt++; $display("FAIL b2b_no_error got=%0d/%0d exp=0/0", fe_cnt, both_hi); end
  endtask

  task automatic test_enable();
    clear_mon();
    send_frame(8'h5A, 1'b1, -1, -1, 2);
    idle(2 * bit_clks);
    send_frame(8'h11, 1'b1, -1, -1, -1);
    idle(2 * bit_clks);
    enable_RX = 1'b1;
    idle(4);
    @(negedge clk);
    vec_cnt++; if (got_q.size() !== 1) begin err_cnt++; $display("FAIL enable_count got=%0d exp=1", got_q.size()); end
    else begin
      vec_cnt++; if (got_q[0] !== 8'h5A) begin err_cnt++; $display("FAIL enable_midframe got=%h exp=5a", got_q[0]); end
    end
    vec_cnt++; if (SBUF_out !== 8'h5A) begin err_cnt++; $display("FAIL enable_gated got=%h exp=5a", SBUF_out); end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    send_frame(8'h81, 1'b1, -1, 4, -1);
    RXD = 1'b1;
    sync_reset = 1'b1;
    tick();
    @(negedge clk);
    vec_cnt++; if (SBUF_out !== 8'h00) begin err_cnt++; $display("FAIL rstmid_sbuf got=%h exp=00", SBUF_out); end
    vec_cnt++; if (rx_active !== 1'b0) begin err_cnt++; $display("FAIL rstmid_active got=%b exp=0", rx_active); end
    vec_cnt++; if (rx_valid !== 1'b0 || frame_error !== 1'b0) begin err_cnt++; $display("FAIL rstmid_pulses got=%b%b exp=00", rx_valid, frame_error); end
    sync_reset = 1'b0;
    idle(10 * bit_clks);
    @(negedge clk);
    vec_cnt++; if (got_q.size() !== 0 || fe_cnt !== 0) begin err_cnt++; $display("FAIL rstmid_discard got=%0d/%0d exp=0/0", got_q.size(), fe_cnt); end
    send_frame(8'h81, 1'b1, -1, -1, -1);
    idle(2 * bit_clks);
    @(negedge clk);
    vec_cnt++; if (got_q.size() !== 1) begin err_cnt++; $display("FAIL rstmid_after_count got=%0d exp=1", got_q.size()); end
    else begin
      vec_cnt++; if (got_q[0] !== 8'h81) begin err_cnt++; $display("FAIL rstmid_after_value got=%h exp=81", got_q[0]); end
    end
  endtask

  task automatic test_fast();
    baud_rate_period_m1 = 16'd3;
    bit_clks = 4;
    idle(8);
    clear_mon();
`ifdef UART_RX_MAJORITY_EN
    send_frame(8'h96, 1'b1, 3, -1, -1);
`else
    send_frame(8'h96, 1'b1, -1, -1, -1);
`endif
    idle(4 * bit_clks);
    @(negedge clk);
    vec_cnt++; if (got_q.size() !== 1) begin err_cnt++; $display("FAIL fast_count got=%0d exp=1", got_q.size()); end
    vec_cnt++; if (SBUF_out !== 8'h96) begin err_cnt++; $display("FAIL fast_value got=%h exp=96", SBUF_out); end
    vec_cnt++; if (fe_cnt !== 0) begin err_cnt++; $display("FAIL fast_fe got=%0d exp=0", fe_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_frame_error();
    test_glitch();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    test_fast();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: BAUD_PERIOD_BITS, 16, width of baud period input and bit-timing counter.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 sync_reset  input  1  synchronous, active-high reset.
REQ-004 enable_RX  input  1  receiver enable; sampled only in IDLE.
REQ-005 baud_rate_period_m1  input  BAUD_PERIOD_BITS  clocks per bit minus 1; legal minimum 3.
REQ-006 RXD  input  1  asynchronous serial line, idle high.
REQ-007 SBUF_out  output  8  last correctly framed byte.
REQ-008 rx_valid  output  1  one-cycle pulse, SBUF_out updated.
REQ-009 frame_error  output  1  one-cycle pulse, stop bit sampled low.
REQ-010 rx_active  output  1  high in every state except IDLE.

Function
REQ-011 The frame SHALL be 8N1: start 0, 8 data bits LSB first, stop 1.
REQ-012 RXD SHALL pass a 2-flop synchronizer reset to 1; "line" below is the synchronized/filtered value.
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP, WAIT_IDLE, one-hot encoded.
REQ-014 IDLE: if enable_RX and line==0, go START and load bit counter with baud_rate_period_m1>>1.
REQ-015 Bit counter SHALL count down; expiry = counter==0 in the same cycle.
REQ-016 START at expiry: line==0 -> DATA, reload counter with baud_rate_period_m1, clear bit index; line==1 -> IDLE (glitch rejected, no output).
REQ-017 DATA at each expiry: shift line into shift-register MSB, increment 3-bit index, reload counter; after the 8th bit go STOP.
REQ-018 STOP at expiry: line==1 -> SBUF_out loaded, rx_valid pulses next cycle, go IDLE; line==0 -> frame_error pulses next cycle, SBUF_out unchanged, go WAIT_IDLE.
REQ-019 WAIT_IDLE SHALL stay until line==1, then go IDLE; it prevents a break condition from being taken as a new start bit.
REQ-020 A new start bit SHALL be accepted the cycle after return to IDLE (back-to-back frames without gap).
REQ-021 enable_RX deasserted mid-frame SHALL NOT abort the frame.
REQ-022 rx_valid and frame_error SHALL never be high together; neither requires acknowledge, and a new byte overwrites SBUF_out.
REQ-023 baud_rate_period_m1 changes mid-frame SHALL take effect at the next reload only.

Reset
REQ-024 sync_reset SHALL force IDLE, SBUF_out=0, rx_valid=0, frame_error=0, rx_active=0, counters=0, synchronizer and filter=all ones.
REQ-025 sync_reset mid-frame SHALL discard the partial byte with no pulse output.

Configuration
REQ-026 Macro UART_RX_MAJORITY_EN defined: line = 2-of-3 majority of the last three synchronized samples (filter adds one cycle latency, single-cycle glitches rejected).
REQ-027 UART_RX_MAJORITY_EN undefined: line = second synchronizer flop directly; no filter registers are present.

Structure
REQ-028 Shared package uart_pkg SHALL hold the state index constants, UART_DATA_BITS=8, and start/stop bit level constants, used by both TX and RX.
REQ-029 The synchronizer plus optional majority filter SHALL be a sub-module, uart_rx_filter.

Verification (baud_rate_period_m1=15 unless stated)
REQ-030 Frame 0xA5, 16 clk/bit -> exactly one rx_valid, SBUF_out=0xA5, frame_error never high.
REQ-031 Stop bit driven 0 for byte 0x3C, then line held low 40 cycles -> one frame_error, SBUF_out keeps prior value, FSM in WAIT_IDLE until RXD high, no second frame.
REQ-032 RXD low pulse of 4 cycles -> return to IDLE at START sample, no rx_valid, no frame_error.
REQ-033 Back-to-back 0x00, 0xFF, 0x55 with zero idle gap -> three rx_valid pulses in order, values correct.
REQ-034 sync_reset asserted during data bit 4 of 0x81 -> all outputs 0 next cycle; following clean frame 0x81 received correctly.
REQ-035 baud_rate_period_m1=3, frame 0x96; with UART_RX_MAJORITY_EN, 1-cycle glitch at bit-3 centre -> SBUF_out=0x96.
